// File: rtl/lzrw1_pkg.sv
// Shared definitions for the LZRW1 compressor/decompressor pair.
// Holds the token formats, the history/hash geometry, the compressor FSM
// states and the 3-byte window hash.
package lzrw1_pkg;

  localparam int unsigned HISTORY_SIZE = 4096;
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned HASH_BITS    = 10;
  localparam int unsigned HASH_SIZE    = 1 << HASH_BITS;
  localparam logic [3:0]  MIN_MATCH    = 4'd3;
  localparam logic [3:0]  MAX_MATCH    = 4'd15;

  // Back-reference token: copy len bytes starting offset bytes back.
  typedef struct packed {
    logic [3:0]  len;
    logic [11:0] offset;
  } compressed_t;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] data;
  } literal_t;

  typedef union packed {
    compressed_t match;
    literal_t    lit;
  } data_in_t;

  typedef enum logic [2:0] {StCollect, StLookup, StVerify, StExtend, StEmit} state_e;

  // ({w0,4'b0} ^ {w1,2'b0} ^ {4'b0,w2}) truncated to HASH_BITS; only w0[5:0]
  // survives the truncation, so only those bits are passed in.
  function automatic logic [HASH_BITS-1:0] hash3(input logic [5:0] b0,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b2);
    return {b0, 4'b0000} ^ {b1, 2'b00} ^ {2'b00, b2};
  endfunction

endpackage

// File: rtl/compressor_if.sv
// Byte-in / token-out stream bundle of the compressor.
// slave  : compressor side (consumes bytes, produces tokens)
// master : producer/consumer side (drives bytes, accepts tokens)
interface compressor_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] data_out;
  logic        control_word_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport slave (
    input  in_byte, in_valid, in_last, out_ready,
    output in_ready, data_out, control_word_out, out_valid, out_last
  );

  modport master (
    output in_byte, in_valid, in_last, out_ready,
    input  in_ready, data_out, control_word_out, out_valid, out_last
  );
endinterface

// File: rtl/compressor_history.sv
// Byte history RAM of the compressor: HISTORY_SIZE x 8, one write port,
// one registered read port (data appears the cycle after the address), no reset.
// Ports: i_clock; i_we/i_waddr/i_wdata write; i_raddr read address; o_rdata.
module compressor_history
  import lzrw1_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [HISTORY_SIZE];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/compressor_top.sv
// LZRW1-style stream compressor. Bytes enter through bus.in_*, tokens leave
// through bus.data_out/control_word_out (literal {8'h00,byte} or match
// {len,offset}). Hash table and FSM live here; history is a sub-module.
// Ports: i_clock; i_reset (synchronous, active low); bus (compressor_if.slave).
module compressor_top
  import lzrw1_pkg::*;
(
  input  logic          i_clock,
  input  logic          i_reset,
  compressor_if.slave   bus
);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pos, r_p0, r_cand;
  logic [7:0]          r_w0, r_w1, r_w2;
  logic [1:0]          r_cnt, r_k;
  logic [3:0]          r_len;
  logic                r_last_seen, r_phase, r_is_match;
  logic [HASH_SIZE-1:0] r_tbl_valid;
  logic [ADDR_W-1:0]   r_tbl_pos [HASH_SIZE];

  logic [HASH_BITS-1:0] w_hash;
  logic [ADDR_W-1:0]   w_entry_pos, w_offset, w_raddr;
  logic [7:0]          w_rd_data, w_win_k;
  logic                w_in_ready, w_in_fire, w_cmp_eq;
  data_in_t            w_tok;

  assign w_hash      = hash3(r_w0[5:0], r_w1, r_w2);
  assign w_entry_pos = r_tbl_pos[w_hash];
  assign w_offset    = r_p0 - w_entry_pos;
  assign w_win_k     = (r_k == 2'd0) ? r_w0 : (r_k == 2'd1) ? r_w1 : r_w2;
  assign w_cmp_eq    = (w_rd_data == w_win_k);
  assign w_raddr     = r_cand + ((r_state == StVerify) ? {10'd0, r_k} : {8'd0, r_len});

  compressor_history u_history (
    .i_clock (i_clock),
    .i_we    (w_in_fire),
    .i_waddr (r_pos),
    .i_wdata (bus.in_byte),
    .i_raddr (w_raddr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= StCollect;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_in_ready           = 1'b0;
    w_tok                = '0;
    bus.out_valid        = 1'b0;
    bus.control_word_out = 1'b0;
    bus.out_last         = 1'b0;
    unique case (r_state)
      StCollect: begin
        w_in_ready = (r_cnt < 2'd3);
        if (w_in_ready && bus.in_valid) begin
          if (r_cnt == 2'd2)    w_state_nxt = StLookup;
          else if (bus.in_last) w_state_nxt = StEmit;
        end
      end
      StLookup: begin
        if (r_tbl_valid[w_hash] && (w_offset != '0)) w_state_nxt = StVerify;
        else                                         w_state_nxt = StEmit;
      end
      StVerify: begin
        if (r_phase) begin
          if (!w_cmp_eq)          w_state_nxt = StEmit;
          else if (r_k == 2'd2)   w_state_nxt = r_last_seen ? StEmit : StExtend;
        end
      end
      StExtend: begin
        // Phase 0 issues the read, phase 1 compares the registered result.
        if (r_phase && bus.in_valid) begin
          if (bus.in_byte == w_rd_data) begin
            w_in_ready = 1'b1;
            if ((r_len == MAX_MATCH - 4'd1) || bus.in_last) w_state_nxt = StEmit;
          end else begin
            w_state_nxt = StEmit;
          end
        end
      end
      StEmit: begin
        bus.out_valid = 1'b1;
        if (r_is_match) begin
          w_tok.match.len      = r_len;
          w_tok.match.offset   = r_p0 - r_cand;
          bus.control_word_out = 1'b1;
          bus.out_last         = r_last_seen;
        end else begin
          w_tok.lit.data = r_w0;
          bus.out_last   = r_last_seen && (r_cnt == 2'd1);
        end
        if (bus.out_ready && (r_is_match || !r_last_seen || r_cnt == 2'd1)) begin
          w_state_nxt = StCollect;
        end
      end
      default: w_state_nxt = StCollect;
    endcase
  end

  assign bus.data_out = w_tok;
  assign bus.in_ready = w_in_ready && i_reset;
  assign w_in_fire    = w_in_ready && bus.in_valid && i_reset;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_pos       <= '0;
      r_p0        <= '0;
      r_cand      <= '0;
      r_w0        <= '0;
      r_w1        <= '0;
      r_w2        <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_len       <= '0;
      r_last_seen <= 1'b0;
      r_phase     <= 1'b0;
      r_is_match  <= 1'b0;
      r_tbl_valid <= '0;
    end else begin
      if (w_in_fire) begin
        r_pos <= r_pos + 12'd1;
        if (bus.in_last) r_last_seen <= 1'b1;
      end
      // Token kind is decided by the state that hands over to EMIT.
      if (r_state != StEmit && w_state_nxt == StEmit) begin
        r_is_match <= (r_state == StExtend) || (r_state == StVerify && w_cmp_eq);
      end
      unique case (r_state)
        StCollect: begin
          if (w_in_fire) begin
            case (r_cnt)
              2'd0: begin
                r_w0 <= bus.in_byte;
                r_p0 <= r_pos;
              end
              2'd1:    r_w1 <= bus.in_byte;
              default: r_w2 <= bus.in_byte;
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
        end
        StLookup: begin
          r_tbl_valid[w_hash] <= 1'b1;
          r_cand  <= w_entry_pos;
          r_k     <= 2'd0;
          r_phase <= 1'b0;
        end
        StVerify: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_k <= r_k + 2'd1;
            if (r_k == 2'd2) r_len <= MIN_MATCH;
          end
        end
        StExtend: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else if (bus.in_valid) begin
            r_phase <= 1'b0;
            if (w_in_fire) r_len <= r_len + 4'd1;
          end
        end
        StEmit: begin
          if (bus.out_ready) begin
            if (r_is_match) begin
              r_cnt       <= 2'd0;
              r_p0        <= r_pos;
              r_last_seen <= 1'b0;
            end else begin
              r_w0  <= r_w1;
              r_w1  <= r_w2;
              r_cnt <= r_cnt - 2'd1;
              r_p0  <= r_p0 + 12'd1;
              if (r_cnt == 2'd1) r_last_seen <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stored positions need no reset: an entry is ignored until its valid bit is set.
  always_ff @(posedge i_clock) begin
    if (i_reset && r_state == StLookup) r_tbl_pos[w_hash] <= r_p0;
  end

endmodule

// File: tb/tb_compressor_top.sv
module tb_compressor_top;

  typedef struct {
    logic [15:0] data;
    logic        ctrl;
    logic        last;
  } tok_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  compressor_if bus ();

  compressor_top dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  tok_t       exp_q [$];
  logic [7:0] in_hist [$];
  logic [7:0] dec_hist [$];
  bit         bp_mode = 1'b0;
  bit         holding = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic exp_tok(input logic [15:0] d, input logic c, input logic l);
    tok_t t;
    t.data = d;
    t.ctrl = c;
    t.last = l;
    exp_q.push_back(t);
  endtask

  // Compare an accepted token with the scoreboard and decode it into dec_hist.
  task automatic consume(input logic [15:0] d, input logic c, input logic l);
    tok_t e;
    int   off;
    int   len;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_token: got %h ctrl %b, expected none", d, c);
    end else begin
      e = exp_q.pop_front();
      check("tok_data", {16'h0, d}, {16'h0, e.data});
      check("tok_ctrl", {31'h0, c}, {31'h0, e.ctrl});
      check("tok_last", {31'h0, l}, {31'h0, e.last});
    end
    if (!c) begin
      dec_hist.push_back(d[7:0]);
    end else begin
      len = int'(d[15:12]);
      off = int'(d[11:0]);
      check("match_offset_ok", {31'h0, (off != 0 && off <= dec_hist.size())}, 32'h1);
      if (off != 0 && off <= dec_hist.size()) begin
        for (int k = 0; k < len; k++) dec_hist.push_back(dec_hist[dec_hist.size() - off]);
      end
    end
  endtask

  // Monitor: decides out_ready each negedge; a token shown with out_ready=1
  // is taken at the next posedge, so it is checked now.
  initial begin : monitor
    logic [15:0] h_data;
    logic        h_ctrl, h_last;
    int          stall;
    bus.out_ready = 1'b1;
    stall = 0;
    h_data = '0;
    h_ctrl = 1'b0;
    h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (!holding) begin
          holding = 1'b1;
          stall   = 0;
          h_data  = bus.data_out;
          h_ctrl  = bus.control_word_out;
          h_last  = bus.out_last;
        end else begin
          check("stall_data", {16'h0, bus.data_out}, {16'h0, h_data});
          check("stall_ctrl", {31'h0, bus.control_word_out}, {31'h0, h_ctrl});
          check("stall_last", {31'h0, bus.out_last}, {31'h0, h_last});
        end
        if (bp_mode && stall < 5) begin
          bus.out_ready = 1'b0;
          stall++;
        end else begin
          bus.out_ready = 1'b1;
          consume(bus.data_out, bus.control_word_out, bus.out_last);
          holding = 1'b0;
        end
      end else begin
        bus.out_ready = !bp_mode;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    holding = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic run_stream(input string s);
    int guard;
    bit acc;
    in_hist.delete();
    dec_hist.delete();
    for (int i = 0; i < s.len(); i++) in_hist.push_back(s[i]);
    for (int i = 0; i < in_hist.size(); i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_byte  = in_hist[i];
      bus.in_last  = (i == in_hist.size() - 1);
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard <= 200) begin
        #1;
        acc = bus.in_ready;
        if (!acc) begin
          guard++;
          @(negedge clk);
        end
      end
      if (!acc) begin
        check("accept_timeout", 32'h0, 32'h1);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || holding) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain", {31'h0, (guard < 2000)}, 32'h1);
    exp_q.delete();
    repeat (10) @(negedge clk);
    #1;
    check("idle_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("decode_len", dec_hist.size(), in_hist.size());
    for (int i = 0; i < in_hist.size() && i < dec_hist.size(); i++) begin
      check("decode_byte", {24'h0, dec_hist[i]}, {24'h0, in_hist[i]});
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    string s20;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    check("post_rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("post_rst_data", {16'h0, bus.data_out}, 32'h0);
    check("post_rst_ctrl", {31'h0, bus.control_word_out}, 32'h0);
    check("post_rst_last", {31'h0, bus.out_last}, 32'h0);

    exp_tok(16'h0041, 1'b0, 1'b0);
    exp_tok(16'h0042, 1'b0, 1'b0);
    exp_tok(16'h0043, 1'b0, 1'b1);
    run_stream("ABC");

    do_reset();
    exp_tok(16'h0041, 1'b0, 1'b0);
    exp_tok(16'h0042, 1'b0, 1'b0);
    exp_tok(16'h0043, 1'b0, 1'b0);
    exp_tok(16'h6003, 1'b1, 1'b1);
    run_stream("ABCABCABC");

    do_reset();
    s20 = "";
    for (int i = 0; i < 20; i++) s20 = {s20, "A"};
    exp_tok(16'h0041, 1'b0, 1'b0);
    exp_tok(16'hF001, 1'b1, 1'b0);
    exp_tok(16'h400F, 1'b1, 1'b1);
    run_stream(s20);

    do_reset();
    exp_tok(16'h0041, 1'b0, 1'b0);
    exp_tok(16'h0042, 1'b0, 1'b0);
    exp_tok(16'h0043, 1'b0, 1'b0);
    exp_tok(16'h0044, 1'b0, 1'b0);
    exp_tok(16'h3004, 1'b1, 1'b0);
    exp_tok(16'h0058, 1'b0, 1'b1);
    run_stream("ABCDABCX");

    do_reset();
    bp_mode = 1'b1;
    exp_tok(16'h0041, 1'b0, 1'b0);
    exp_tok(16'h0042, 1'b0, 1'b0);
    exp_tok(16'h0043, 1'b0, 1'b0);
    exp_tok(16'h6003, 1'b1, 1'b1);
    run_stream("ABCABCABC");
    bp_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
